// File: rtl/cal_pkg.sv
// Shared calendar types and helpers for the month/date setting controller.
// Provides the mode encoding, month limits and the days-in-month table.
package cal_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MON = 2'd1,
    SET_DAY = 2'd2
  } state_e;

  localparam logic [3:0] MONTH_MIN = 4'd1;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  function automatic logic [4:0] dim(input logic [3:0] month, input logic leap);
    logic [4:0] d;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = leap ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] next_month(input logic [3:0] month);
    return (month >= MONTH_MAX) ? MONTH_MIN : month + 4'd1;
  endfunction

endpackage

// File: rtl/pb_one_pulse.sv
// Rising-edge detector for a debounced button level; the pulse is high for
// the single cycle in which the level is seen high after a low sample.
module pb_one_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level_in,
  output logic pulse_out
);

  logic level_q;

  // Registered copy of the level for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_in;
    end
  end

  assign pulse_out = level_in & ~level_q;

endmodule

// File: rtl/date_set_ctrl.sv
// Month/date setting controller: RUN / SET_MON / SET_DAY sequencing, button
// increments with hold-to-repeat, and daily advance of the date while running.
module date_set_ctrl
  import cal_pkg::*;
#(
  parameter int REPEAT_DLY = 200,
  parameter int REPEAT_PER = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pb_mode,
  input  logic       pb_inc,
  input  logic       day_tick,
  input  logic       leap,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [1:0] mode,
  output logic       set_active
);

  localparam int CNT_W = $clog2(REPEAT_DLY + 1);
  localparam logic [CNT_W-1:0] RPT_FIRE   = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DLY - REPEAT_PER);

  state_e           state_q;
  logic             set_active_q;
  logic [3:0]       month_q, month_d;
  logic [4:0]       day_q, day_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_cnt_inc;
  logic             mode_pulse, inc_pulse, rpt_fire, inc_ev, set_mode;
  logic [3:0]       nm;
  logic [4:0]       dim_cur, dim_nm, day_clamp;

  pb_one_pulse u_mode_edge (.clk(clk), .rst_n(rst_n), .level_in(pb_mode), .pulse_out(mode_pulse));
  pb_one_pulse u_inc_edge  (.clk(clk), .rst_n(rst_n), .level_in(pb_inc),  .pulse_out(inc_pulse));

  assign set_mode    = (state_q != RUN);
  assign nm          = next_month(month_q);
  assign dim_cur     = dim(month_q, leap);
  assign dim_nm      = dim(nm, leap);
  assign day_clamp   = (day_q > dim_cur) ? dim_cur : day_q;
  assign rpt_cnt_inc = rpt_cnt_q + CNT_W'(1);
  // A mode change in the same cycle swallows any pending increment
  assign inc_ev      = (inc_pulse | rpt_fire) & ~mode_pulse;

  // Hold-to-repeat counter; reload keeps later repeats REPEAT_PER apart
  always_comb begin
    rpt_cnt_d = rpt_cnt_q;
    rpt_fire  = 1'b0;
    if (!pb_inc || mode_pulse || !set_mode) begin
      rpt_cnt_d = '0;
    end else if (rpt_cnt_inc == RPT_FIRE) begin
      rpt_fire  = 1'b1;
      rpt_cnt_d = RPT_RELOAD;
    end else begin
      rpt_cnt_d = rpt_cnt_inc;
    end
  end

  // Next date: tick in RUN, increments in set modes, otherwise clamp to dim
  always_comb begin
    month_d = month_q;
    day_d   = day_clamp;
    case (state_q)
      RUN: begin
        if (day_tick) begin
          if (day_q < dim_cur) begin
            day_d = day_q + 5'd1;
          end else begin
            day_d   = 5'd1;
            month_d = nm;
          end
        end else begin
          day_d = day_clamp;
        end
      end
      SET_MON: begin
        if (inc_ev) begin
          month_d = nm;
          day_d   = (day_q > dim_nm) ? dim_nm : day_q;
        end else begin
          day_d = day_clamp;
        end
      end
      SET_DAY: begin
        if (inc_ev) begin
          day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
        end else begin
          day_d = day_clamp;
        end
      end
      default: begin
        day_d = day_clamp;
      end
    endcase
  end

  // Mode FSM with registered blink enable, plus date and repeat registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      set_active_q <= 1'b0;
      month_q      <= MONTH_MIN;
      day_q        <= 5'd1;
      rpt_cnt_q    <= '0;
    end else begin
      month_q   <= month_d;
      day_q     <= day_d;
      rpt_cnt_q <= rpt_cnt_d;
      if (mode_pulse) begin
        case (state_q)
          RUN: begin
            state_q      <= SET_MON;
            set_active_q <= 1'b1;
          end
          SET_MON: begin
            state_q      <= SET_DAY;
            set_active_q <= 1'b1;
          end
          SET_DAY: begin
            state_q      <= RUN;
            set_active_q <= 1'b0;
          end
          default: begin
            state_q      <= RUN;
            set_active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign month      = month_q;
  assign day        = day_q;
  assign mode       = state_q;
  assign set_active = set_active_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed scoreboard bench for date_set_ctrl with a short repeat delay.
module tb_date_set_ctrl;

  localparam int DLY = 4;
  localparam int PER = 2;

  logic       clk = 1'b0;
  logic       rst_n, pb_mode, pb_inc, day_tick, leap;
  logic [3:0] month;
  logic [4:0] day;
  logic [1:0] mode;
  logic       set_active;

  typedef struct {
    logic [3:0] m;
    logic [4:0] d;
    logic [1:0] md;
    logic       sa;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "init";
  logic [4:0] ed;

  date_set_ctrl #(.REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .clk(clk), .rst_n(rst_n), .pb_mode(pb_mode), .pb_inc(pb_inc),
    .day_tick(day_tick), .leap(leap), .month(month), .day(day),
    .mode(mode), .set_active(set_active)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expected post-edge state, compare after the edge
  task automatic step(input logic r, input logic pm, input logic pi, input logic dt,
                      input logic [3:0] em, input logic [4:0] edy, input logic [1:0] emd);
    exp_t e, x;
    rst_n = r; pb_mode = pm; pb_inc = pi; day_tick = dt;
    e.m = em; e.d = edy; e.md = emd; e.sa = (emd != 2'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    assert (month === x.m && day === x.d && mode === x.md && set_active === x.sa)
    else begin
      errors++;
      $error("FAIL %s: month/day/mode/set_active got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
             phase, month, day, mode, set_active, x.m, x.d, x.md, x.sa);
    end
  endtask

  // One-cycle press followed by one-cycle release, same expectation on both
  task automatic tap(input logic pm, input logic pi, input logic dt,
                     input logic [3:0] em, input logic [4:0] edy, input logic [1:0] emd);
    step(1'b1, pm, pi, dt, em, edy, emd);
    step(1'b1, 1'b0, 1'b0, 1'b0, em, edy, emd);
  endtask

  initial begin
    rst_n = 1'b0; pb_mode = 1'b0; pb_inc = 1'b0; day_tick = 1'b0; leap = 1'b0;
    @(posedge clk);
    #1;

    phase = "reset";
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 5'd1, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 5'd1, 2'd0);

    phase = "mode_seq";
    tap(1'b1, 1'b0, 1'b0, 4'd1, 5'd1, 2'd1);
    tap(1'b1, 1'b0, 1'b0, 4'd1, 5'd1, 2'd2);
    tap(1'b1, 1'b0, 1'b0, 4'd1, 5'd1, 2'd0);

    phase = "mode_hold";
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 5'd1, 2'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 5'd1, 2'd1);

    phase = "set_month";
    for (int m = 2; m <= 12; m++) tap(1'b0, 1'b1, 1'b0, 4'(m), 5'd1, 2'd1);

    phase = "set_day";
    tap(1'b1, 1'b0, 1'b0, 4'd12, 5'd1, 2'd2);
    for (int d = 2; d <= 31; d++) tap(1'b0, 1'b1, 1'b0, 4'd12, 5'(d), 2'd2);

    phase = "to_set_mon";
    tap(1'b1, 1'b0, 1'b0, 4'd12, 5'd31, 2'd0);
    tap(1'b1, 1'b0, 1'b0, 4'd12, 5'd31, 2'd1);

    phase = "month_wrap";
    tap(1'b0, 1'b1, 1'b0, 4'd1, 5'd31, 2'd1);
    phase = "month_clamp";
    tap(1'b0, 1'b1, 1'b0, 4'd2, 5'd28, 2'd1);

    phase = "mode_and_inc";
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 5'd28, 2'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 5'd28, 2'd2);

    leap = 1'b1;
    phase = "leap_day";
    tap(1'b0, 1'b1, 1'b0, 4'd2, 5'd29, 2'd2);
    leap = 1'b0;
    phase = "leap_clamp";
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 5'd28, 2'd2);
    leap = 1'b1;
    phase = "leap_hold";
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 5'd28, 2'd2);

    phase = "to_run";
    tap(1'b1, 1'b0, 1'b0, 4'd2, 5'd28, 2'd0);
    phase = "tick_feb28";
    tap(1'b0, 1'b0, 1'b1, 4'd2, 5'd29, 2'd0);
    phase = "tick_feb29";
    tap(1'b0, 1'b0, 1'b1, 4'd3, 5'd1, 2'd0);
    leap = 1'b0;

    phase = "tick_frozen";
    tap(1'b1, 1'b0, 1'b0, 4'd3, 5'd1, 2'd1);
    tap(1'b0, 1'b0, 1'b1, 4'd3, 5'd1, 2'd1);

    phase = "to_dec";
    for (int m = 4; m <= 12; m++) tap(1'b0, 1'b1, 1'b0, 4'(m), 5'd1, 2'd1);
    phase = "dec_days";
    tap(1'b1, 1'b0, 1'b0, 4'd12, 5'd1, 2'd2);
    for (int d = 2; d <= 31; d++) tap(1'b0, 1'b1, 1'b0, 4'd12, 5'(d), 2'd2);

    phase = "run_rollover";
    tap(1'b1, 1'b0, 1'b0, 4'd12, 5'd31, 2'd0);
    tap(1'b0, 1'b0, 1'b1, 4'd1, 5'd1, 2'd0);

    phase = "inc_in_run";
    tap(1'b0, 1'b1, 1'b0, 4'd1, 5'd1, 2'd0);

    phase = "tick_and_mode";
    tap(1'b1, 1'b0, 1'b1, 4'd1, 5'd2, 2'd1);

    phase = "auto_repeat";
    tap(1'b1, 1'b0, 1'b0, 4'd1, 5'd2, 2'd2);
    ed = 5'd2;
    for (int k = 1; k <= 9; k++) begin
      if (k == 1 || (k >= DLY && ((k - DLY) % PER) == 0)) ed = ed + 5'd1;
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, ed, 2'd2);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, ed, 2'd2);

    phase = "reset_mid";
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, ed + 5'd1, 2'd2);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, ed + 5'd1, 2'd2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 5'd1, 2'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 5'd1, 2'd0);
    phase = "after_reset";
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 5'd1, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 5'd1, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
